// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter with a one-word holding register, so that back-to-back words go out with no gap.
// Defining P2S_PARITY_EN appends a parity bit to every frame. Set ODD_PARITY to choose the parity sense.
module p2s_serializer #(
   parameter int DATA_W     = 16,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_serial,
   output logic              o_serial_valid,
   output logic              o_frame_start,
   output logic              o_busy
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef P2S_PARITY_EN
      ,PARITY = 2'd2
`endif
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] hold_reg;
   logic              hold_full;
   logic [DATA_W-1:0] shreg;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] shreg_nxt;
   logic              first_bit;
   logic              frame_done;
   logic              load;

`ifdef P2S_PARITY_EN
   logic              par_bit;
`else
   logic              unused_odd_parity;
   assign unused_odd_parity = ODD_PARITY;
`endif

   assign shreg_nxt = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
   assign first_bit = MSB_FIRST ? hold_reg[DATA_W-1] : hold_reg[0];

   // frame_done marks the last slot of the current frame. A reload can replace that slot's exit without leaving a gap.
   always_comb begin
      frame_done = 1'b0;
`ifdef P2S_PARITY_EN
      frame_done = (state == PARITY);
`else
      frame_done = (state == SHIFT) && (cnt == LAST);
`endif
      load = i_enable && hold_full && ((state == IDLE) || frame_done);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         hold_reg       <= '0;
         hold_full      <= 1'b0;
         shreg          <= '0;
         cnt            <= '0;
         o_serial       <= 1'b0;
         o_serial_valid <= 1'b0;
         o_frame_start  <= 1'b0;
`ifdef P2S_PARITY_EN
         par_bit        <= 1'b0;
`endif
      end else begin
         // Accept requires an empty holder and load requires a full one, so the two never clash on hold_full.
         if (i_valid && !hold_full) begin
            hold_reg  <= i_data;
            hold_full <= 1'b1;
         end
         if (load) begin
            hold_full      <= 1'b0;
            shreg          <= hold_reg;
            cnt            <= '0;
            state          <= SHIFT;
            o_serial       <= first_bit;
            o_serial_valid <= 1'b1;
            o_frame_start  <= 1'b1;
`ifdef P2S_PARITY_EN
            par_bit        <= (^hold_reg) ^ ODD_PARITY;
`endif
         end else if (i_enable) begin
            if (state == SHIFT && cnt != LAST) begin
               shreg         <= shreg_nxt;
               cnt           <= cnt + CW'(1);
               o_serial      <= MSB_FIRST ? shreg_nxt[DATA_W-1] : shreg_nxt[0];
               o_frame_start <= 1'b0;
            end
`ifdef P2S_PARITY_EN
            else if (state == SHIFT) begin
               state         <= PARITY;
               o_serial      <= par_bit;
               o_frame_start <= 1'b0;
            end
`endif
            else if (frame_done) begin
               state          <= IDLE;
               o_serial       <= 1'b0;
               o_serial_valid <= 1'b0;
               o_frame_start  <= 1'b0;
            end
         end
      end
   end

   assign o_ready = !hold_full;
   assign o_busy  = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: a 16-bit MSB-first unit and an 8-bit LSB-first unit, checked every cycle against a frame-queue model.
module tb_p2s_serializer;

   localparam int W0 = 16;
   localparam int W1 = 8;
   localparam bit ODD0 = 1'b0;
   localparam bit ODD1 = 1'b1;
`ifdef P2S_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL0 = W0 + PAR;
   localparam int FL1 = W1 + PAR;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic [15:0] d0 = '0;
   logic v0 = 1'b0;
   logic [7:0] d1 = '0;
   logic v1 = 1'b0;
   logic rdy0, ser0, sv0, fs0, busy0;
   logic rdy1, ser1, sv1, fs1, busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   p2s_serializer #(.DATA_W(W0), .MSB_FIRST(1'b1), .ODD_PARITY(ODD0)) u_d16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_data(d0), .i_valid(v0),
      .o_ready(rdy0), .o_serial(ser0), .o_serial_valid(sv0), .o_frame_start(fs0), .o_busy(busy0));

   p2s_serializer #(.DATA_W(W1), .MSB_FIRST(1'b0), .ODD_PARITY(ODD1)) u_d8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_data(d1), .i_valid(v1),
      .o_ready(rdy1), .o_serial(ser1), .o_serial_valid(sv1), .o_frame_start(fs1), .o_busy(busy1));

   // Reference model: a held word becomes a list of frame bits, and each enabled edge shows the next bit of that list.
   bit          m_hold [2];
   logic [63:0] m_word [2];
   bit          m_bit  [2];
   bit          m_vld  [2];
   bit          m_fs   [2];
   bit          rest   [2][$];

   always @(posedge clk or negedge rst_n) begin
      bit          vin [2];
      logic [63:0] din [2];
      bit          old_hold, b, p;
      int          w;
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            m_hold[c] = 0; m_word[c] = '0; m_bit[c] = 0; m_vld[c] = 0; m_fs[c] = 0;
            rest[c].delete();
         end
      end else begin
         vin[0] = v0; din[0] = 64'(d0);
         vin[1] = v1; din[1] = 64'(d1);
         for (int c = 0; c < 2; c++) begin
            old_hold = m_hold[c];
            if (en) begin
               if (rest[c].size() > 0) begin
                  m_bit[c] = rest[c].pop_front(); m_fs[c] = 0; m_vld[c] = 1;
               end else if (old_hold) begin
                  w = (c == 0) ? W0 : W1;
                  p = (c == 0) ? ODD0 : ODD1;
                  for (int i = 0; i < w; i++) begin
                     b = (c == 0) ? m_word[c][w-1-i] : m_word[c][i];
                     p = p ^ m_word[c][i];
                     if (i == 0) m_bit[c] = b;
                     else rest[c].push_back(b);
                  end
                  if (PAR != 0) rest[c].push_back(p);
                  m_fs[c] = 1; m_vld[c] = 1; m_hold[c] = 0;
               end else begin
                  m_bit[c] = 0; m_fs[c] = 0; m_vld[c] = 0;
               end
            end
            if (vin[c] && !old_hold) begin
               m_hold[c] = 1; m_word[c] = din[c];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("ready0",  64'(rdy0),  64'(!m_hold[0]));
      chk("serial0", 64'(ser0),  64'(m_bit[0]));
      chk("svalid0", 64'(sv0),   64'(m_vld[0]));
      chk("fstart0", 64'(fs0),   64'(m_fs[0]));
      chk("busy0",   64'(busy0), 64'(m_vld[0] | m_hold[0]));
      chk("ready1",  64'(rdy1),  64'(!m_hold[1]));
      chk("serial1", 64'(ser1),  64'(m_bit[1]));
      chk("svalid1", 64'(sv1),   64'(m_vld[1]));
      chk("fstart1", 64'(fs1),   64'(m_fs[1]));
      chk("busy1",   64'(busy1), 64'(m_vld[1] | m_hold[1]));
   endtask

   // One clock, with the source dropping valid after a handshake. Outputs are compared on the falling edge.
   task automatic tick_h();
      bit a0, a1;
      a0 = v0 && rdy0;
      a1 = v1 && rdy1;
      @(posedge clk);
      @(negedge clk);
      if (a0) v0 = 1'b0;
      if (a1) v1 = 1'b0;
      check_all();
   endtask

   task automatic collect(input int c, input int ncyc, output logic [63:0] bits,
                          output int nb, output int nfs);
      bits = '0; nb = 0; nfs = 0;
      for (int n = 0; n < ncyc; n++) begin
         tick_h();
         if ((c == 0) ? sv0 : sv1) begin
            bits = {bits[62:0], (c == 0) ? ser0 : ser1};
            nb++;
            if ((c == 0) ? fs0 : fs1) nfs++;
         end
      end
   endtask

   logic [63:0] bits, exp_bits;
   int nb, nfs, cnt;

   initial begin
      // reset state
      #1 check_all();
      chk("rst_ready0", 64'(rdy0), 64'd1);
      chk("rst_busy0", 64'(busy0), 64'd0);
      tick_h();
      rst_n = 1'b1;
      en = 1'b1;
      tick_h();

      // 1: single 0xCCCC frame
      d0 = 16'hCCCC; v0 = 1'b1;
      collect(0, FL0 + 4, bits, nb, nfs);
      exp_bits = (PAR != 0) ? 64'({16'hCCCC, 1'b0}) : 64'h0000_0000_0000_CCCC;
      chk("t1_bits", bits, exp_bits);
      chk("t1_nbits", 64'(nb), 64'(FL0));
      chk("t1_nfs", 64'(nfs), 64'd1);
      chk("t1_busy_end", 64'(busy0), 64'd0);

      // 2: back-to-back words, second offered while the first shifts
      d0 = 16'hA5A5; v0 = 1'b1;
      tick_h();
      d0 = 16'h0001; v0 = 1'b1;
      collect(0, 2 * FL0 + 4, bits, nb, nfs);
      exp_bits = (PAR != 0) ? 64'({16'hA5A5, 1'b0, 16'h0001, 1'b1}) : 64'h0000_0000_A5A5_0001;
      chk("t2_bits", bits, exp_bits);
      chk("t2_nbits", 64'(nb), 64'(2 * FL0));
      chk("t2_nfs", 64'(nfs), 64'd2);

      // 3: enable toggling 1,0,1,0 stretches every bit to two clocks
      en = 1'b0; d0 = 16'hCCCC; v0 = 1'b1;
      tick_h();
      cnt = 0;
      for (int i = 0; i < 2 * FL0 + 6; i++) begin
         en = (i % 2 == 0);
         tick_h();
         if (sv0) cnt++;
      end
      en = 1'b1;
      chk("t3_valid_clocks", 64'(cnt), 64'(2 * FL0));

      // 4: asynchronous reset mid-frame with a word held
      d0 = 16'hF0F0; v0 = 1'b1;
      tick_h();
      d0 = 16'h1234; v0 = 1'b1;
      for (int i = 0; i < 6; i++) tick_h();
      chk("t4_held", 64'(rdy0), 64'd0);
      #2 rst_n = 1'b0;
      #1 check_all();
      chk("t4_rst_svalid", 64'(sv0), 64'd0);
      chk("t4_rst_ready", 64'(rdy0), 64'd1);
      chk("t4_rst_busy", 64'(busy0), 64'd0);
      v0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick_h();
      d0 = 16'h8001; v0 = 1'b1;
      collect(0, FL0 + 4, bits, nb, nfs);
      exp_bits = (PAR != 0) ? 64'({16'h8001, 1'b0}) : 64'h0000_0000_0000_8001;
      chk("t4_after_bits", bits, exp_bits);
      chk("t4_after_nfs", 64'(nfs), 64'd1);

      // 5: 8-bit LSB-first unit
      d1 = 8'h01; v1 = 1'b1;
      collect(1, FL1 + 4, bits, nb, nfs);
      exp_bits = (PAR != 0) ? 64'({8'h80, 1'b0}) : 64'h80;
      chk("t5_bits", bits, exp_bits);
      chk("t5_nbits", 64'(nb), 64'(FL1));
      d1 = 8'hCC; v1 = 1'b1;
      collect(1, FL1 + 4, bits, nb, nfs);
      exp_bits = (PAR != 0) ? 64'({8'h33, 1'b1}) : 64'h33;
      chk("t5_cc_bits", bits, exp_bits);

      // 6: odd-weight word
      d0 = 16'hCCCD; v0 = 1'b1;
      collect(0, FL0 + 4, bits, nb, nfs);
      exp_bits = (PAR != 0) ? 64'({16'hCCCD, 1'b1}) : 64'h0000_0000_0000_CCCD;
      chk("t6_bits", bits, exp_bits);

      // randomized traffic on both units
      for (int n = 0; n < 800; n++) begin
         en = ($urandom_range(3) != 0);
         if (!v0 && $urandom_range(1) == 1) begin d0 = 16'($urandom); v0 = 1'b1; end
         if (!v1 && $urandom_range(1) == 1) begin d1 = 8'($urandom); v1 = 1'b1; end
         if (n == 400) begin
            #2 rst_n = 1'b0;
            #1 check_all();
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick_h();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
